// File: rtl/avalon_spi_fifo_slave_pkg.sv
// Shared definitions for the Avalon-MM SPI FIFO slave: register map, STATUS/CONTROL/IRQ bit
// positions and the transfer engine state encoding.
package avs_spi_pkg;

  localparam logic [7:0] ADDR_TXDATA  = 8'h00;
  localparam logic [7:0] ADDR_RXDATA  = 8'h01;
  localparam logic [7:0] ADDR_STATUS  = 8'h02;
  localparam logic [7:0] ADDR_CONTROL = 8'h03;
  localparam logic [7:0] ADDR_IRQ_EN  = 8'h04;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_RX_EMPTY = 3;
  localparam int STAT_RX_FULL  = 4;
  localparam int STAT_TX_OVF   = 5;
  localparam int STAT_RX_OVF   = 6;
  localparam int STAT_RX_UNF   = 7;
  localparam int STAT_TX_LEVEL = 8;
  localparam int STAT_RX_LEVEL = 16;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_RX_EN  = 1;
  localparam int CTRL_FLUSH  = 7;

  localparam int IRQ_RX_NOT_EMPTY = 0;
  localparam int IRQ_TX_EMPTY     = 1;
  localparam int IRQ_ERR          = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_DONE
  } eng_state_t;

endpackage

// File: rtl/avalon_spi_fifo_slave_if.sv
// Avalon-MM slave bus bundle between the interconnect (master) and the SPI FIFO slave.
interface avalon_spi_fifo_slave_if;
  logic        chip_select;
  logic [7:0]  address;
  logic        write;
  logic        read;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        wait_request;

  modport master (
    output chip_select, address, write, read, write_data,
    input  read_data, wait_request
  );

  modport slave (
    input  chip_select, address, write, read, write_data,
    output read_data, wait_request
  );
endinterface

// File: rtl/avalon_spi_fifo_slave_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, wr_idx;
  logic             do_pop, do_push, eff_push, eff_pop;

  assign empty    = (level == '0);
  assign full     = (level == (AW+1)'(DEPTH));
  assign head     = mem[rd_ptr];
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  // A push landing in a flush cycle survives as the sole entry.
  assign eff_push = flush ? push : do_push;
  assign eff_pop  = ~flush & do_pop;
  assign wr_idx   = flush ? '0 : wr_ptr;

  always_ff @(posedge clk) begin
    if (eff_push) mem[wr_idx] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= AW'(eff_push);
      level  <= (AW+1)'(eff_push);
    end else begin
      wr_ptr <= wr_ptr + AW'(eff_push);
      rd_ptr <= rd_ptr + AW'(eff_pop);
      level  <= level + (AW+1)'(eff_push) - (AW+1)'(eff_pop);
    end
  end
endmodule

// File: rtl/avalon_spi_fifo_slave.sv
// Avalon-MM slave buffering SPI words through TX/RX FIFOs with an autonomous transfer engine.
// Define AVS_SPI_IRQ_EN to build the maskable level interrupt and the IRQ_EN register.
module avalon_spi_fifo_slave
  import avs_spi_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  avalon_spi_fifo_slave_if.slave avs,
  output logic                 irq,
  output logic                 go_transfer,
  output logic [DATA_W-1:0]    data_write_to_spi,
  input  logic                 spi_busy,
  input  logic                 spi_done,
  input  logic [DATA_W-1:0]    data_read_from_spi,
  output logic                 transfer_complete
);
  eng_state_t state;

  logic rd_pend, rd_rx_hit, rd_start, rd_acc;
  logic wr_acc, wr_tx, wr_ctrl, wr_status, flush;
  logic ctrl_enable, ctrl_rx_en;
  logic [2:0] sticky, sticky_set, sticky_clr, irq_en_rd;
  logic [31:0] status_word;

  logic tx_push, tx_pop, tx_full, tx_empty;
  logic rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_W-1:0] tx_head, rx_head;
  logic [$clog2(TX_DEPTH):0] tx_level;
  logic [$clog2(RX_DEPTH):0] rx_level;

  // Reads take two cycles: the first stalls and registers read_data, the second completes.
  assign rd_start         = avs.chip_select & avs.read & ~rd_pend;
  assign rd_acc           = avs.chip_select & avs.read & rd_pend;
  assign avs.wait_request = rd_start;

  assign wr_acc    = avs.chip_select & avs.write;
  assign wr_tx     = wr_acc & (avs.address == ADDR_TXDATA);
  assign wr_ctrl   = wr_acc & (avs.address == ADDR_CONTROL);
  assign wr_status = wr_acc & (avs.address == ADDR_STATUS);
  assign flush     = wr_ctrl & avs.write_data[CTRL_FLUSH];

  assign tx_push = wr_tx;
  assign tx_pop  = (state == S_LOAD) & ~tx_empty;
  assign rx_push = (state == S_WAIT_DONE) & spi_done & ctrl_rx_en;
  assign rx_pop  = rd_acc & rd_rx_hit;

  assign sticky_set = {rd_start & (avs.address == ADDR_RXDATA) & rx_empty,
                       rx_push & rx_full & ~rx_pop,
                       wr_tx & tx_full & ~tx_pop};
  assign sticky_clr = (wr_status ? avs.write_data[7:5] : 3'b000) | {3{flush}};

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .push(tx_push), .push_data(avs.write_data[DATA_W-1:0]), .pop(tx_pop),
    .head(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .push(rx_push), .push_data(data_read_from_spi), .pop(rx_pop),
    .head(rx_head), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  always_comb begin
    status_word                          = '0;
    status_word[STAT_BUSY]               = (state != S_IDLE);
    status_word[STAT_TX_FULL]            = tx_full;
    status_word[STAT_TX_EMPTY]           = tx_empty;
    status_word[STAT_RX_EMPTY]           = rx_empty;
    status_word[STAT_RX_FULL]            = rx_full;
    status_word[STAT_RX_UNF:STAT_TX_OVF] = sticky;
    status_word[STAT_TX_LEVEL +: 8]      = 8'(tx_level);
    status_word[STAT_RX_LEVEL +: 8]      = 8'(rx_level);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_pend       <= 1'b0;
      rd_rx_hit     <= 1'b0;
      avs.read_data <= '0;
      ctrl_enable   <= 1'b0;
      ctrl_rx_en    <= 1'b0;
      sticky        <= '0;
    end else begin
      rd_pend   <= rd_start;
      rd_rx_hit <= rd_start & (avs.address == ADDR_RXDATA) & ~rx_empty;
      sticky    <= (sticky & ~sticky_clr) | sticky_set;
      if (wr_ctrl) begin
        ctrl_enable <= avs.write_data[CTRL_ENABLE];
        ctrl_rx_en  <= avs.write_data[CTRL_RX_EN];
      end
      if (rd_start) begin
        case (avs.address)
          ADDR_RXDATA:  avs.read_data <= rx_empty ? 32'd0 : 32'(rx_head);
          ADDR_STATUS:  avs.read_data <= status_word;
          ADDR_CONTROL: avs.read_data <= {30'd0, ctrl_rx_en, ctrl_enable};
          ADDR_IRQ_EN:  avs.read_data <= {29'd0, irq_en_rd};
          default:      avs.read_data <= '0;
        endcase
      end
    end
  end

  // LOAD re-checks emptiness so a flush racing the IDLE->LOAD step never ships a stale word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      go_transfer       <= 1'b0;
      transfer_complete <= 1'b0;
      data_write_to_spi <= '0;
    end else begin
      go_transfer       <= 1'b0;
      transfer_complete <= 1'b0;
      case (state)
        S_IDLE:  if (ctrl_enable & ~tx_empty & ~spi_busy) state <= S_LOAD;
        S_LOAD: begin
          if (tx_empty) begin
            state <= S_IDLE;
          end else begin
            data_write_to_spi <= tx_head;
            go_transfer       <= 1'b1;
            state             <= S_START;
          end
        end
        S_START: state <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (spi_done) begin
            transfer_complete <= 1'b1;
            state             <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef AVS_SPI_IRQ_EN
  logic [2:0] irq_en;
  logic [2:0] irq_cond;

  assign irq_cond  = {|sticky, tx_empty, ~rx_empty};
  assign irq_en_rd = irq_en;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_en <= '0;
      irq    <= 1'b0;
    end else begin
      if (wr_acc & (avs.address == ADDR_IRQ_EN)) irq_en <= avs.write_data[2:0];
      irq <= |(irq_en & irq_cond);
    end
  end
`else
  assign irq_en_rd = '0;
  assign irq       = 1'b0;
`endif

endmodule

// File: doc/avalon_spi_fifo_slave.md
# avalon_spi_fifo_slave

Parametrised Avalon-MM slave fronting the SPI transfer core: buffers CPU writes in a TX FIFO, runs SPI word transfers autonomously, and collects received words in an RX FIFO. Sits between the Avalon interconnect and the SPI shift engine, replacing per-word handshaking with a register map, status/sticky flags and an optional maskable interrupt.

## Interface
- DATA_W, 32, SPI word width (1..32); Avalon data stays 32 bit
- TX_DEPTH, 8, TX FIFO entries (power of 2, ≥2)
- RX_DEPTH, 8, RX FIFO entries (power of 2, ≥2)
- clk  in  1  single system clock
- reset_n  in  1  reset, synchronous and active-low
- chip_select  in  1  Avalon select; gates read/write only, never clears state
- address  in  8  word address
- write / read  in  1  Avalon strobes
- write_data  in  32  write data
- read_data  out  32  registered read data
- wait_request  out  1  Avalon wait
- irq  out  1  level interrupt
- go_transfer  out  1  one-cycle start pulse to SPI core
- data_write_to_spi  out  DATA_W  word to shift out
- spi_busy  in  1  SPI core busy
- spi_done  in  1  one-cycle pulse, shift finished, same clock domain
- data_read_from_spi  in  DATA_W  received word, valid with spi_done
- transfer_complete  out  1  one-cycle pulse per finished word

## Operation
- Registers: 0x00 TXDATA (W: push write_data[DATA_W-1:0]; R: 0); 0x01 RXDATA (R: pop, zero-extended); 0x02 STATUS (R; W1C bits 5-7); 0x03 CONTROL (RW: bit0 enable, bit1 rx_enable, bit7 flush self-clearing, reads 0); 0x04 IRQ_EN; other addresses read 0, writes ignored.
- STATUS: [0] busy (FSM≠IDLE), [1] tx_full, [2] tx_empty, [3] rx_empty, [4] rx_full, [5] tx_overflow, [6] rx_overflow, [7] rx_underflow, [15:8] tx_level, [23:16] rx_level, rest 0.
- TXDATA write when full and no same-cycle pop: word dropped, tx_overflow set. With same-cycle pop: accepted.
- RXDATA read when empty: returns 0, no pop, rx_underflow set.
- Engine FSM: IDLE -> LOAD when enable & !tx_empty & !spi_busy; LOAD: pop TX head into data_write_to_spi -> START; START: go_transfer=1 -> WAIT_DONE; WAIT_DONE: on spi_done, transfer_complete=1, push data_read_from_spi if rx_enable (full: drop, set rx_overflow) -> IDLE.
- Clearing enable only stops new LOADs; an in-flight word completes.
- Flush: empties both FIFOs and clears sticky flags in the write cycle; in-flight word still completes and its RX word is pushed after flush.
- Sticky flag set and W1C in same cycle: set wins.

## Timing
- Reset (reset_n low at clk edge): all outputs 0, FSM IDLE, FIFOs empty, CONTROL/IRQ_EN 0.
- Write: wait_request=0, accepted in the cycle asserted.
- Read: wait_request = chip_select & read & ~rd_pend; cycle 1 wait_request=1, read_data loaded; cycle 2 wait_request=0, master samples; RX pop at end of cycle 2. rd_pend clears after cycle 2.
- Min turnaround: TX write to go_transfer = 3 cycles (write edge, LOAD, START).
- Per-word overhead 3 cycles + SPI time; spi_done to next go_transfer ≥3 cycles.
- FIFO simultaneous push/pop: both performed, level unchanged; RX read and engine push in same cycle both take effect.
- read_data holds last value until next read.

## Configuration
- AVS_SPI_IRQ_EN defined: IRQ_EN bits [0] rx_not_empty, [1] tx_empty, [2] any overflow/underflow sticky; irq registered = |(IRQ_EN & cond), one cycle after cause.
- Undefined: irq tied 0, IRQ_EN reads 0, writes ignored.

## Structure
- Package avs_spi_pkg: register address localparams, STATUS/CONTROL bit indices, FSM state enum.
- Sub-module sync_fifo (WIDTH, DEPTH; push/pop/full/empty/level), instantiated for TX and RX.

## Test plan
- Reset then read STATUS -> 0x0000_000C (tx_empty, rx_empty), wait_request high exactly 1 cycle.
- enable=1, rx_enable=1, write 0xA5 to TXDATA; SPI model returns 0x5A -> go_transfer 3 cycles after write, data_write_to_spi=0xA5, RXDATA read 0x5A, rx_level 1→0.
- enable=0, write 9 words with TX_DEPTH=8 -> tx_full, tx_level 8, tx_overflow=1; write STATUS 0x20 -> cleared.
- Read RXDATA when empty -> 0, rx_underflow=1, no level change.
- 9 transfers with RX_DEPTH=8, no reads -> rx_overflow=1, first 8 words retained in order.
- AVS_SPI_IRQ_EN, IRQ_EN=1, one transfer -> irq high 1 cycle after RX push, low 1 cycle after pop emptying RX; reset_n low mid-WAIT_DONE -> all outputs 0 next edge.
